expr_stream_checker: RTL and testbench

- Byte-serial ASCII infix-expression recogniser; one character per accepted cycle.
- Successor to the single-digit "digit (op digit)*" string recogniser.
- Generalised to multi-digit operands, four operators, bounded parenthesis nesting, a valid strobe, and an '=' terminator with a pass/fail result pulse.
- Sits between the UART/keyboard byte source and the calculator front end.

---
 rtl/expr_stream_checker.sv | 148 ++++++++++++++
 tb/tb_expr_stream_checker.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/expr_stream_checker.sv
`default_nettype none
// ============================================================================
// Module   : expr_stream_checker
// Brief    : Byte-serial ASCII infix-expression recogniser with '=' result
//            pulse. Optional macro EXPR_SPACE_SKIP_EN makes ' ' a no-op.
// Revision : 1.0 - initial release
// ============================================================================
module expr_stream_checker #(
  parameter int MAX_DEPTH  = 4,
  parameter int MAX_DIGITS = 3,
  parameter int DEPTH_W    = 4
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               in_valid,
  input  logic [7:0]         in,
  output logic               out,
  output logic               err,
  output logic [DEPTH_W-1:0] depth,
  output logic               done,
  output logic               done_ok
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  typedef enum logic [1:0] {
    S_EXP = 2'd0,
    S_NUM = 2'd1,
    S_CLS = 2'd2,
    S_ERR = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               done_q,  done_d;
  logic               ok_q,    ok_d;

  logic w_is_digit;
  logic w_is_op;
  logic w_is_open;
  logic w_is_close;
  logic w_is_term;
  logic w_complete;
  logic w_depth_max;
  logic w_depth_zero;

  assign w_is_digit   = (in >= 8'h30) && (in <= 8'h39);
  assign w_is_op      = (in == 8'h2B) || (in == 8'h2D) || (in == 8'h2A) || (in == 8'h2F);
  assign w_is_open    = (in == 8'h28);
  assign w_is_close   = (in == 8'h29);
  assign w_is_term    = (in == 8'h3D);
  assign w_depth_max  = (depth_q == DEPTH_W'(MAX_DEPTH));
  assign w_depth_zero = (depth_q == '0);
  assign w_complete   = ((state_q == S_NUM) || (state_q == S_CLS)) && w_depth_zero;

`ifdef EXPR_SPACE_SKIP_EN
  logic w_is_space;
  assign w_is_space = (in == 8'h20);
`endif

  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    ok_d    = 1'b0;
    if (in_valid) begin
      if (w_is_term) begin
        // '=' restarts from any state, including S_ERR
        done_d  = 1'b1;
        ok_d    = w_complete;
        state_d = S_EXP;
        depth_d = '0;
        cnt_d   = '0;
      end
`ifdef EXPR_SPACE_SKIP_EN
      else if (w_is_space) begin
      end
`endif
      else begin
        case (state_q)
          S_EXP: begin
            if (w_is_digit) begin
              state_d = S_NUM;
              cnt_d   = CNT_W'(1);
            end else if (w_is_open && !w_depth_max) begin
              depth_d = depth_q + DEPTH_W'(1);
            end else begin
              state_d = S_ERR;
            end
          end
          S_NUM: begin
            if (w_is_digit) begin
              if (cnt_q == CNT_W'(MAX_DIGITS)) state_d = S_ERR;
              else                             cnt_d   = cnt_q + CNT_W'(1);
            end else if (w_is_op) begin
              state_d = S_EXP;
              cnt_d   = '0;
            end else if (w_is_close && !w_depth_zero) begin
              state_d = S_CLS;
              depth_d = depth_q - DEPTH_W'(1);
              cnt_d   = '0;
            end else begin
              state_d = S_ERR;
            end
          end
          S_CLS: begin
            if (w_is_op) begin
              state_d = S_EXP;
            end else if (w_is_close && !w_depth_zero) begin
              depth_d = depth_q - DEPTH_W'(1);
            end else begin
              state_d = S_ERR;
            end
          end
          default: begin
            state_d = S_ERR;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_EXP;
      depth_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      ok_q    <= ok_d;
    end
  end

  assign out     = w_complete;
  assign err     = (state_q == S_ERR);
  assign depth   = depth_q;
  assign done    = done_q;
  assign done_ok = ok_q;

endmodule
`default_nettype wire

// File: tb/tb_expr_stream_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_expr_stream_checker
// Brief    : Self-checking bench for expr_stream_checker; directed sequences
//            plus random characters against a history-scanning reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_expr_stream_checker;

  localparam int MAX_DEPTH  = 4;
  localparam int MAX_DIGITS = 3;
  localparam int DEPTH_W    = 4;

  logic               clk = 1'b0;
  logic               clr;
  logic               in_valid;
  logic [7:0]         in_ch;
  logic               out;
  logic               err;
  logic [DEPTH_W-1:0] depth;
  logic               done;
  logic               done_ok;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] hist[$];
  bit         exp_done;
  bit         exp_ok;

  always #5 clk = ~clk;

  expr_stream_checker #(
    .MAX_DEPTH (MAX_DEPTH),
    .MAX_DIGITS(MAX_DIGITS),
    .DEPTH_W   (DEPTH_W)
  ) u_dut (
    .clk     (clk),
    .clr     (clr),
    .in_valid(in_valid),
    .in      (in_ch),
    .out     (out),
    .err     (err),
    .depth   (depth),
    .done    (done),
    .done_ok (done_ok)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Re-scan the characters since the last restart, judging each against the
  // token before it: 0 = nothing/operator/'(', 1 = digit, 2 = ')'.
  function automatic void eval(output bit ok, output bit e, output int d);
    int prev = 0;
    int run  = 0;
    d = 0;
    e = 0;
    foreach (hist[i]) begin
      logic [7:0] c;
      c = hist[i];
      if (e) break;
`ifdef EXPR_SPACE_SKIP_EN
      if (c == " ") continue;
`endif
      if (c >= "0" && c <= "9") begin
        if (prev == 2 || (prev == 1 && run == MAX_DIGITS)) e = 1;
        else begin
          run  = (prev == 1) ? run + 1 : 1;
          prev = 1;
        end
      end else if (c == "+" || c == "-" || c == "*" || c == "/") begin
        if (prev == 0) e = 1;
        else prev = 0;
      end else if (c == "(") begin
        if (prev != 0 || d == MAX_DEPTH) e = 1;
        else d++;
      end else if (c == ")") begin
        if (prev == 0 || d == 0) e = 1;
        else begin
          d--;
          prev = 2;
        end
      end else begin
        e = 1;
      end
    end
    ok = !e && prev != 0 && d == 0;
  endfunction

  task automatic check_model(input string tag);
    bit ok, e;
    int d;
    eval(ok, e, d);
    check({tag, ".out"},     32'(out),     32'(ok));
    check({tag, ".err"},     32'(err),     32'(e));
    check({tag, ".depth"},   32'(depth),   32'(d));
    check({tag, ".done"},    32'(done),    32'(exp_done));
    check({tag, ".done_ok"}, 32'(done_ok), 32'(exp_ok));
  endtask

  task automatic step(input string tag, input bit v, input logic [7:0] c);
    bit ok, e;
    int d;
    @(negedge clk);
    in_valid = v;
    in_ch    = c;
    @(posedge clk);
    #1;
    exp_done = 0;
    exp_ok   = 0;
    if (v) begin
      if (c == "=") begin
        eval(ok, e, d);
        exp_done = 1;
        exp_ok   = ok;
        hist.delete();
      end else begin
        hist.push_back(c);
      end
    end
    check_model(tag);
  endtask

  task automatic send_str(input string tag, input string s);
    for (int i = 0; i < s.len(); i++) step(tag, 1'b1, s[i]);
  endtask

  initial begin
    clr      = 1'b0;
    in_valid = 1'b0;
    in_ch    = 8'h00;
    exp_done = 0;
    exp_ok   = 0;
    #12;
    check("rst.out",   32'(out),   0);
    check("rst.err",   32'(err),   0);
    check("rst.depth", 32'(depth), 0);
    check("rst.done",  32'(done),  0);
    @(negedge clk);
    clr = 1'b1;

    send_str("plus", "1+1");
    step("plus_eq", 1'b1, "=");

    send_str("paren", "((123)*4)");
    check("paren.out_final", 32'(out), 1);
    step("paren_eq", 1'b1, "=");
    check("paren.done_ok_const", 32'(done_ok), 1);
    step("paren_idle", 1'b0, "=");

    send_str("digits", "1234");
    check("digits.err_const", 32'(err), 1);
    step("digits_eq", 1'b1, "=");
    check("digits.done_ok_const", 32'(done_ok), 0);
    step("eq_eq", 1'b1, "=");

    send_str("deep", "(((((");
    check("deep.depth_const", 32'(depth), 4);
    step("deep_close", 1'b1, ")");
    check("deep.depth_frozen", 32'(depth), 4);
    step("deep_eq", 1'b1, "=");

    send_str("unary", "-5");
    step("unary_eq", 1'b1, "=");
    send_str("lead0", "007/0");
    step("lead0_eq", 1'b1, "=");

    send_str("async", "7+");
    @(posedge clk);
    #2;
    clr = 1'b0;
    #1;
    hist.delete();
    exp_done = 0;
    exp_ok   = 0;
    check_model("async_clr");
    #1;
    clr = 1'b1;
    step("async_5", 1'b1, "5");
    check("async.out_const", 32'(out), 1);
    step("async_eq", 1'b1, "=");

    send_str("space", "1 + 2");
    step("space_eq", 1'b1, "=");
`ifdef EXPR_SPACE_SKIP_EN
    check("space.done_ok_const", 32'(done_ok), 1);
`else
    check("space.done_ok_const", 32'(done_ok), 0);
`endif

    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [7:0] c;
      r = $urandom_range(0, 99);
      if      (r < 45) c = 8'h30 + 8'($urandom_range(0, 9));
      else if (r < 65) begin
        case ($urandom_range(0, 3))
          0:       c = "+";
          1:       c = "-";
          2:       c = "*";
          default: c = "/";
        endcase
      end
      else if (r < 75) c = "(";
      else if (r < 85) c = ")";
      else if (r < 91) c = "=";
      else if (r < 95) c = " ";
      else             c = (r < 98) ? "a" : ".";
      step("rand", $urandom_range(0, 9) != 0, c);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
